// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch / program-load stage:
//   - DEPTH / AW : program memory size and address width
//   - NOP        : fill instruction (ADDI R0,R0,0)
//   - state_t    : fetch FSM state encoding (ST_CHECK is used only when
//                  INSTR_FETCH_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [7:0] NOP   = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_HALT  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

endpackage

// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
// DEPTH x 8 program memory: synchronous write, asynchronous read, no reset.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data (combinational)
// -----------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Contents deliberately survive reset; only a new load overwrites them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch and program-load stage in front of the cpu core.
// A 16-word program is streamed in over a valid/ready byte interface, then
// instructions are served combinationally from the core's pc. Addresses at
// or beyond the loaded length read as NOP and send the stage to HALT. The
// core is held in reset (cpu_run low) until a complete load has finished.
//
// Optional feature macro: INSTR_FETCH_CHECKSUM_EN
//   When defined, the byte after the final program byte must be the XOR of
//   all program bytes; a mismatch returns to IDLE with load_err set.
//
// Handshake: a byte transfers on a rising edge where ld_valid and ld_ready
// are both high. ld_ready is a pure decode of the registered state, so it
// never depends on ld_valid in the same cycle.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-low reset
//   load_start   in   begin (re)load; honoured in IDLE, RUN, HALT
//   ld_valid     in   loader byte valid
//   ld_data      in   loader byte
//   ld_last      in   marks the final program byte
//   ld_ready     out  loader may transfer (LOAD, and CHECK when enabled)
//   pc           in   program counter from the core
//   instruction  out  instruction to the core
//   cpu_run      out  core released from reset (RUN/HALT)
//   halted       out  pc has left the program
//   prog_len     out  number of loaded words, 0..DEPTH
//   load_err     out  sticky load fault, cleared by load_start
//   state_dbg    out  current FSM state
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int         DEPTH = instr_fetch_pkg::DEPTH,
    parameter int         AW    = instr_fetch_pkg::AW,
    parameter logic [7:0] NOP   = instr_fetch_pkg::NOP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [7:0]    pc,
    output logic [7:0]    instruction,
    output logic          cpu_run,
    output logic          halted,
    output logic [AW:0]   prog_len,
    output logic          load_err,
    output logic [2:0]    state_dbg
);

    import instr_fetch_pkg::*;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [7:0]      rd_data;
    logic            accept;
    logic            mem_we;
    logic            in_range;
    logic            last_slot;
`ifdef INSTR_FETCH_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    always_comb begin
        ld_ready = (state == ST_LOAD);
`ifdef INSTR_FETCH_CHECKSUM_EN
        if (state == ST_CHECK) begin
            ld_ready = 1'b1;
        end
`endif
    end

    assign accept    = ld_valid & ld_ready;
    assign mem_we    = accept & (state == ST_LOAD);
    assign last_slot = (wr_ptr == AW'(DEPTH - 1));
    // Full 8-bit compare: upper pc bits must count, so pc=8'h12 is outside
    // a 16-word program even though pc[AW-1:0] would alias into it.
    assign in_range  = (pc < 8'(prog_len));
    assign cpu_run   = (state == ST_RUN) | (state == ST_HALT);
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    always_comb begin
        instruction = NOP;
        if ((state == ST_RUN) && in_range) begin
            instruction = rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Program memory
    // ------------------------------------------------------------------
    instr_fetch_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (ld_data),
        .rd_addr (pc[AW-1:0]),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Either an explicit last byte or a full memory ends the load.
                if (accept && (ld_last || last_slot)) begin
`ifdef INSTR_FETCH_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                end else if (!in_range) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                end
            end
`ifdef INSTR_FETCH_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_nxt = (ld_data == csum) ? ST_RUN : ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load bookkeeping: write pointer, length, error flag, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            prog_len <= '0;
            load_err <= 1'b0;
`ifdef INSTR_FETCH_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_HALT: begin
                    if (load_start) begin
                        wr_ptr   <= '0;
                        prog_len <= '0;
                        load_err <= 1'b0;
`ifdef INSTR_FETCH_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
`ifdef INSTR_FETCH_CHECKSUM_EN
                        csum   <= csum ^ ld_data;
`endif
                        if (ld_last) begin
                            prog_len <= {1'b0, wr_ptr} + (AW+1)'(1);
                        end else if (last_slot) begin
                            // Memory filled without a last marker: run what
                            // we have but flag the overflow.
                            prog_len <= (AW+1)'(DEPTH);
                            load_err <= 1'b1;
                        end
                    end
                end
`ifdef INSTR_FETCH_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept && (ld_data != csum)) begin
                        prog_len <= '0;
                        load_err <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. Stimulus pushes expected observations into
// a queue; a monitor on the falling edge pops and compares them against the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [7:0] NOP_I = 8'h40;

    localparam int K_INSTR = 0;
    localparam int K_RUN   = 1;
    localparam int K_HALT  = 2;
    localparam int K_READY = 3;
    localparam int K_ERR   = 4;
    localparam int K_LEN   = 5;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         step;
    } exp_t;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       load_start = 1'b0;
    logic       ld_valid   = 1'b0;
    logic [7:0] ld_data    = 8'h00;
    logic       ld_last    = 1'b0;
    logic [7:0] pc         = 8'h00;
    logic       ld_ready;
    logic [7:0] instruction;
    logic       cpu_run;
    logic       halted;
    logic [4:0] prog_len;
    logic       load_err;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .halted      (halted),
        .prog_len    (prog_len),
        .load_err    (load_err),
        .state_dbg   (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    exp_t       exp_q[$];
    exp_t       m;
    logic [7:0] obs;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step     = 0;
    logic [7:0] prog [16];

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_INSTR: return instruction;
            K_RUN:   return {7'b0, cpu_run};
            K_HALT:  return {7'b0, halted};
            K_READY: return {7'b0, ld_ready};
            K_ERR:   return {7'b0, load_err};
            K_LEN:   return {3'b0, prog_len};
            default: return 8'h00;
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_INSTR: return "instruction";
            K_RUN:   return "cpu_run";
            K_HALT:  return "halted";
            K_READY: return "ld_ready";
            K_ERR:   return "load_err";
            K_LEN:   return "prog_len";
            default: return "unknown";
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m   = exp_q.pop_front();
            obs = observe(m.kind);
            n_checks++;
            if (obs !== m.val) begin
                n_fail++;
                $display("FAIL %s step %0d: got 0x%0h expected 0x%0h",
                         kname(m.kind), m.step, obs, m.val);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic expect_out(input int kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.step = step;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step++;
    endtask

    // Streams prog[0..n-1]; gap inserts an idle cycle between bytes.
    // With the checksum feature a trailing checksum byte is sent.
    task automatic load_prog(input int n, input bit use_last, input bit gap,
                             input bit bad_csum);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = use_last && (i == n - 1);
            cs       = cs ^ prog[i];
            expect_out(K_READY, 8'h01);
            if (i == n - 1) begin
                expect_out(K_RUN, 8'h00);
            end
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (gap && (i != n - 1)) begin
                expect_out(K_RUN, 8'h00);
                tick();
            end
        end
`ifdef INSTR_FETCH_CHECKSUM_EN
        ld_valid = 1'b1;
        ld_data  = bad_csum ? 8'h00 : cs;
        expect_out(K_READY, 8'h01);
        expect_out(K_RUN, 8'h00);
        tick();
        ld_valid = 1'b0;
`else
        if (bad_csum) begin
            cs = 8'h00;
        end
`endif
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Watchdog: the sequence is short, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        tick();
        expect_out(K_READY, 8'h00);
        expect_out(K_RUN,   8'h00);
        expect_out(K_HALT,  8'h00);
        expect_out(K_ERR,   8'h00);
        expect_out(K_LEN,   8'h00);
        expect_out(K_INSTR, NOP_I);
        tick();
        reset = 1'b1;
        tick();

        // load_start with a simultaneous byte in IDLE: byte not taken
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 8'hAA;
        expect_out(K_READY, 8'h00);
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        expect_out(K_READY, 8'h01);
        expect_out(K_RUN,   8'h00);
        expect_out(K_INSTR, NOP_I);

        // 10-byte sum program, ld_valid toggling every other cycle
        prog[0] = 8'h43; prog[1] = 8'h43; prog[2] = 8'h43; prog[3] = 8'h41;
        prog[4] = 8'h54; prog[5] = 8'h68; prog[6] = 8'h8F; prog[7] = 8'h29;
        prog[8] = 8'h55; prog[9] = 8'hC7;
        pc = 8'h00;
        load_prog(10, 1'b1, 1'b1, 1'b0);
        expect_out(K_RUN,   8'h01);
        expect_out(K_LEN,   8'd10);
        expect_out(K_ERR,   8'h00);
        expect_out(K_READY, 8'h00);
        expect_out(K_HALT,  8'h00);
        for (int k = 0; k < 10; k++) begin
            pc = 8'(k);
            expect_out(K_INSTR, prog[k]);
            tick();
        end

        // Out-of-range pc: NOP at once, halted one cycle later
        pc = 8'd12;
        expect_out(K_INSTR, NOP_I);
        expect_out(K_HALT,  8'h00);
        tick();
        pc = 8'd3;
        expect_out(K_HALT,  8'h01);
        expect_out(K_RUN,   8'h01);
        expect_out(K_INSTR, NOP_I);

        // Reload from HALT; cpu_run drops the following cycle
        load_start = 1'b1;
        expect_out(K_RUN, 8'h01);
        tick();
        load_start = 1'b0;
        pc = 8'h00;
        expect_out(K_RUN,   8'h00);
        expect_out(K_HALT,  8'h00);
        expect_out(K_LEN,   8'h00);
        expect_out(K_READY, 8'h01);

        // 16 bytes with no last marker: overflow run with load_err
        for (int i = 0; i < 16; i++) begin
            prog[i] = 8'h10 + 8'(i);
        end
        load_prog(16, 1'b0, 1'b0, 1'b0);
        expect_out(K_RUN, 8'h01);
        expect_out(K_LEN, 8'd16);
        expect_out(K_ERR, 8'h01);
        pc = 8'd15;
        expect_out(K_INSTR, 8'h1F);
        tick();
        pc = 8'd0;
        expect_out(K_INSTR, 8'h10);
        tick();
        // Upper pc bits count: 8'h12 is beyond 16 words
        pc = 8'h12;
        expect_out(K_INSTR, NOP_I);
        expect_out(K_HALT,  8'h00);
        tick();
        pc = 8'h05;
        expect_out(K_HALT,  8'h01);
        expect_out(K_INSTR, NOP_I);

        // load_start clears the sticky error
        start_load();
        pc = 8'h00;
        expect_out(K_ERR, 8'h00);

`ifdef INSTR_FETCH_CHECKSUM_EN
        // Checksum match (0x41^0x42^0x43 = 0x40) then mismatch (0x00)
        prog[0] = 8'h41; prog[1] = 8'h42; prog[2] = 8'h43;
        load_prog(3, 1'b1, 1'b0, 1'b0);
        expect_out(K_RUN, 8'h01);
        expect_out(K_LEN, 8'd3);
        pc = 8'd2;
        expect_out(K_INSTR, 8'h43);
        tick();
        pc = 8'd0;
        start_load();
        load_prog(3, 1'b1, 1'b0, 1'b1);
        expect_out(K_RUN,   8'h00);
        expect_out(K_ERR,   8'h01);
        expect_out(K_LEN,   8'h00);
        expect_out(K_READY, 8'h00);
        start_load();
`endif

        // Reset asserted on byte 5 of a load
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i + 1);
            tick();
        end
        ld_data = 8'h05;
        reset   = 1'b0;
        tick();
        reset    = 1'b1;
        ld_valid = 1'b0;
        expect_out(K_READY, 8'h00);
        expect_out(K_LEN,   8'h00);
        expect_out(K_RUN,   8'h00);
        expect_out(K_ERR,   8'h00);
        expect_out(K_INSTR, NOP_I);
        tick();

        // Fresh load succeeds
        start_load();
        prog[0] = 8'h61; prog[1] = 8'h62; prog[2] = 8'h63;
        load_prog(3, 1'b1, 1'b0, 1'b0);
        expect_out(K_RUN, 8'h01);
        expect_out(K_LEN, 8'd3);
        expect_out(K_ERR, 8'h00);
        pc = 8'd0;
        expect_out(K_INSTR, 8'h61);
        tick();
        pc = 8'd2;
        expect_out(K_INSTR, 8'h63);
        tick();
        pc = 8'd3;
        expect_out(K_INSTR, NOP_I);
        expect_out(K_HALT,  8'h00);
        tick();
        expect_out(K_HALT, 8'h01);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and program-load stage sitting directly upstream of `cpu`. It holds a 16-word program memory that is filled once over a valid/ready byte stream. It then supplies `cpu.instruction` combinationally from `cpu.pc`, and substitutes a NOP once the PC runs past the loaded program. It also releases the core from reset only after a complete load.

## Interface
Parameters:
- `DEPTH`, 16: program words (jump targets are 4-bit).
- `AW`, 4: memory address width, log2(DEPTH).
- `NOP`, 8'h40: fill instruction (ADDI R0,R0,0).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_start`  in  1  begin (re)load; honoured in IDLE, RUN, HALT.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_last`  in  1  qualifies final program byte.
- `ld_ready`  out  1  high only in LOAD (and CHECK when enabled).
- `pc`  in  8  from `cpu.pc`.
- `instruction`  out  8  to `cpu.instruction`.
- `cpu_run`  out  1  high in RUN/HALT; top drives `cpu.reset = ~cpu_run`.
- `halted`  out  1  PC has left the program.
- `prog_len`  out  5  number of loaded words, 0..16.
- `load_err`  out  1  sticky load fault, cleared by `load_start`.

## Operation
- FSM states: IDLE, LOAD, RUN, HALT (plus CHECK under the macro).
- IDLE:
  - `load_start` -> LOAD.
  - Clears `wr_ptr`, `prog_len`, `load_err`.
- LOAD:
  - Each cycle with `ld_valid & ld_ready`: `mem[wr_ptr] <= ld_data`, then `wr_ptr++`.
  - Accepted byte with `ld_last` -> RUN; `prog_len = wr_ptr+1`.
  - 16th accepted byte without `ld_last` -> RUN with `prog_len = 16` and `load_err = 1`.
  - `load_start` is ignored in LOAD.
- RUN:
  - If `pc < prog_len`: `instruction = mem[pc[AW-1:0]]`.
  - Otherwise: `instruction = NOP`, and the state goes to HALT on the next edge.
  - `pc` bits above AW count in the compare (pc = 8'h12 is out of program).
- HALT:
  - `halted = 1`; `instruction = NOP` regardless of pc.
  - `cpu_run` stays high so core registers are preserved.
- RUN/HALT + `load_start`:
  - -> LOAD, `cpu_run` drops the following cycle.
  - Clears `wr_ptr`, `prog_len`, `halted`, `load_err`.
- `instruction = NOP` in IDLE and LOAD.
- Reset (any state, including mid-load):
  - State returns to IDLE.
  - `wr_ptr = 0`, `prog_len = 0`, `ld_ready = 0`, `cpu_run = 0`, `halted = 0`, `load_err = 0`, `instruction = NOP`.
  - Memory contents are not reset.

## Timing
- `ld_ready` is a registered-state decode, with no combinational path from `ld_valid`.
- Write latency is 1 cycle. The `cpu_run` rise is the cycle after the last accepted byte.
- Instruction read is combinational from `pc` (zero latency), matching the core's single-cycle PC update.
- `halted` asserts 1 cycle after the first out-of-range `pc`. The NOP appears in the same cycle.
- `load_start` with `ld_valid` in the same cycle while in IDLE: the byte is not accepted (`ld_ready` is still low).

## Configuration
- `INSTR_FETCH_CHECKSUM_EN`:
  - Defined: a CHECK state follows the `ld_last` byte. The next accepted byte must equal the XOR of all program bytes.
    - Match -> RUN.
    - Mismatch -> IDLE with `load_err = 1` and `prog_len = 0`.
    - The 16-byte overflow case also passes through CHECK.
  - Undefined: no CHECK state, the XOR register is removed, and `ld_last` goes directly to RUN.

## Structure
- Package `instr_fetch_pkg`: state enum, `NOP` constant, `DEPTH`/`AW` localparams.
- Sub-module `instr_fetch_mem`: DEPTH×8 register array, synchronous write, asynchronous read, no reset.
- Top `instr_fetch`: FSM, `wr_ptr`, `prog_len`, range compare, checksum.

## Test plan
- Load the 10-byte sum program (`0x43,0x43,0x43,0x41,0x54,0x68,0x8F,0x29,0x55,0xC7`, last on byte 10) and wire it to `cpu` -> `prog_len = 10`, `cpu_run` rises 1 cycle after the last byte, and `r0 = 10` after 4 instructions.
- Back-to-back load with `ld_valid` toggling every other cycle -> exactly 10 writes, and `mem[k]` matches byte k.
- Load 16 bytes with no `ld_last` -> RUN, `prog_len = 16`, `load_err = 1`.
- In RUN, drive `pc = 12` with `prog_len = 10` -> `instruction = 0x40` immediately, and `halted = 1` next cycle.
- Assert reset low at byte 5 of a load -> IDLE, `prog_len = 0`, `ld_ready = 0`. A fresh load then succeeds.
- With `INSTR_FETCH_CHECKSUM_EN`, load 3 bytes `0x41,0x42,0x43` with checksum `0x40` -> RUN. With checksum `0x00` -> IDLE and `load_err = 1`.
